// File: rtl/pipelined_alu_mc.sv
// Registered, valid/ready-handshaked ALU with an iterative shift-add unsigned multiply.
// Single-cycle ops load the result registers on the accepting edge; MULTU iterates one bit per edge.
module pipelined_alu_mc #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   src1,
  input  logic [WIDTH-1:0]   src2,
  input  logic [SHAMT_W-1:0] shamt,
  input  logic [5:0]         funct,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   result,
  output logic [WIDTH-1:0]   result_hi,
  output logic               zero,
  output logic               carry,
  output logic               busy
);

  localparam logic [5:0] F_ADDU  = 6'h09;
  localparam logic [5:0] F_SUBU  = 6'h0A;
  localparam logic [5:0] F_AND   = 6'h11;
  localparam logic [5:0] F_OR    = 6'h12;
  localparam logic [5:0] F_SLL   = 6'h21;
  localparam logic [5:0] F_SRL   = 6'h22;
  localparam logic [5:0] F_MULTU = 6'h19;

  typedef enum logic {S_IDLE, S_MUL} state_t;

  state_t               state_q, state_d;
  logic                 out_valid_q, out_valid_d;
  logic [WIDTH-1:0]     res_q, res_d, res_hi_q, res_hi_d;
  logic                 zero_q, zero_d, carry_q, carry_d;
  logic [2*WIDTH-1:0]   prod_q, prod_d;
  logic [WIDTH-1:0]     mcand_q, mcand_d;
  logic [SHAMT_W-1:0]   cnt_q, cnt_d;

  logic                 accept;
  logic [WIDTH-1:0]     alu_res;
  logic                 alu_c;
  logic [WIDTH:0]       hi_sum;
  logic [2*WIDTH-1:0]   prod_step;

  assign in_ready  = !rst && (state_q == S_IDLE) && (!out_valid_q || out_ready);
  assign accept    = in_valid && in_ready;
  assign out_valid = out_valid_q;
  assign result    = res_q;
  assign result_hi = res_hi_q;
  assign zero      = zero_q;
  assign carry     = carry_q;
  assign busy      = (state_q == S_MUL);

  // Shift/pad tricks expose the bit shifted out at a fixed position, giving the carry for free.
  always_comb begin
    alu_res = '0;
    alu_c   = 1'b0;
    case (funct)
      F_ADDU:  {alu_c, alu_res} = {1'b0, src1} + {1'b0, src2};
      F_SUBU:  begin alu_res = src1 - src2; alu_c = (src1 < src2); end
      F_AND:   alu_res = src1 & src2;
      F_OR:    alu_res = src1 | src2;
      F_SLL:   {alu_c, alu_res} = {1'b0, src1} << shamt;
      F_SRL:   {alu_res, alu_c} = {src1, 1'b0} >> shamt;
      default: ;
    endcase
  end

  // Low half of prod_q starts as the multiplier and is shifted out as the product shifts in.
  assign hi_sum    = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, mcand_q} : '0);
  assign prod_step = {hi_sum, prod_q[WIDTH-1:1]};

  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q;
    res_d       = res_q;
    res_hi_d    = res_hi_q;
    zero_d      = zero_q;
    carry_d     = carry_q;
    prod_d      = prod_q;
    mcand_d     = mcand_q;
    cnt_d       = cnt_q;
    if (out_ready) out_valid_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (funct == F_MULTU) begin
            state_d = S_MUL;
            prod_d  = {{WIDTH{1'b0}}, src2};
            mcand_d = src1;
            cnt_d   = '0;
          end else begin
            res_d       = alu_res;
            res_hi_d    = '0;
            carry_d     = alu_c;
            zero_d      = (alu_res == '0);
            out_valid_d = 1'b1;
          end
        end
      end
      S_MUL: begin
        prod_d = prod_step;
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == SHAMT_W'(WIDTH-1)) begin
          state_d     = S_IDLE;
          res_d       = prod_step[WIDTH-1:0];
          res_hi_d    = prod_step[2*WIDTH-1:WIDTH];
          carry_d     = |prod_step[2*WIDTH-1:WIDTH];
          zero_d      = (prod_step == '0);
          out_valid_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      out_valid_q <= 1'b0;
      res_q       <= '0;
      res_hi_q    <= '0;
      zero_q      <= 1'b0;
      carry_q     <= 1'b0;
      prod_q      <= '0;
      mcand_q     <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      res_q       <= res_d;
      res_hi_q    <= res_hi_d;
      zero_q      <= zero_d;
      carry_q     <= carry_d;
      prod_q      <= prod_d;
      mcand_q     <= mcand_d;
      cnt_q       <= cnt_d;
    end
  end

endmodule

// File: tb/tb_pipelined_alu_mc.sv
// Self-checking bench for pipelined_alu_mc: directed scenarios plus random ops
// compared against a plain-arithmetic reference model.
module tb_pipelined_alu_mc;
  localparam int W  = 32;
  localparam int SW = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid, in_ready;
  logic [W-1:0]  src1, src2;
  logic [SW-1:0] shamt;
  logic [5:0]    funct;
  logic          out_valid, out_ready;
  logic [W-1:0]  result, result_hi;
  logic          zero, carry, busy;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [W-1:0] lo;
    logic [W-1:0] hi;
    logic         z;
    logic         c;
  } exp_t;

  pipelined_alu_mc #(.WIDTH(W), .SHAMT_W(SW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .src1(src1), .src2(src2), .shamt(shamt), .funct(funct),
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .result_hi(result_hi), .zero(zero), .carry(carry), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic exp_t model(input logic [5:0] f, input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic [SW-1:0] sh);
    exp_t e;
    logic [2*W-1:0] p, wa, wb;
    int s;
    s = int'(sh);
    wa = {{W{1'b0}}, a};
    wb = {{W{1'b0}}, b};
    e.lo = '0; e.hi = '0; e.c = 1'b0;
    case (f)
      6'h09: begin p = wa + wb; e.lo = p[W-1:0]; e.c = p[W]; end
      6'h0A: begin e.lo = a - b; e.c = (a < b); end
      6'h11: e.lo = a & b;
      6'h12: e.lo = a | b;
      6'h21: begin e.lo = a << s; e.c = (s != 0) ? a[W-s] : 1'b0; end
      6'h22: begin e.lo = a >> s; e.c = (s != 0) ? a[s-1] : 1'b0; end
      6'h19: begin p = wa * wb; e.lo = p[W-1:0]; e.hi = p[2*W-1:W]; e.c = (e.hi != 0); end
      default: ;
    endcase
    e.z = (e.lo == 0) && (e.hi == 0);
    return e;
  endfunction

  // Issues one op with out_ready=1 and returns at the sample where out_valid first rises.
  task automatic run_op(input logic [5:0] f, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [SW-1:0] sh, input string nm);
    exp_t e;
    int n, nb, expn;
    e = model(f, a, b, sh);
    n = 0; nb = 0;
    expn = (f == 6'h19) ? W : 0;
    funct = f; src1 = a; src2 = b; shamt = sh; in_valid = 1'b1; out_ready = 1'b1;
    #1;
    total++;
    if (in_ready !== 1'b1) begin bad++; $display("FAIL %s in_ready got %b want 1", nm, in_ready); end
    @(posedge clk); #1;
    in_valid = 1'b0; src1 = $urandom; src2 = $urandom; shamt = SW'($urandom); funct = 6'($urandom);
    while (out_valid !== 1'b1 && n < 200) begin
      if (busy === 1'b1 && in_ready === 1'b0) nb++;
      @(posedge clk); #1;
      n++;
    end
    total++;
    if (n !== expn) begin bad++; $display("FAIL %s latency got %0d edges want %0d", nm, n, expn); end
    if (f == 6'h19) begin
      total++;
      if (nb !== W) begin bad++; $display("FAIL %s busy cycles got %0d want %0d", nm, nb, W); end
    end
    total++;
    if ({result, result_hi, zero, carry} !== {e.lo, e.hi, e.z, e.c}) begin
      bad++;
      $display("FAIL %s result got lo=%h hi=%h z=%b c=%b want lo=%h hi=%h z=%b c=%b",
               nm, result, result_hi, zero, carry, e.lo, e.hi, e.z, e.c);
    end
  endtask

  task automatic drain();
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    src1 = '0; src2 = '0; shamt = '0; funct = '0;
    #2;
    total++;
    if ({in_ready, out_valid, result, result_hi, zero, carry, busy} !== '0) begin
      bad++;
      $display("FAIL reset_state got rdy=%b v=%b lo=%h hi=%h z=%b c=%b busy=%b want all 0",
               in_ready, out_valid, result, result_hi, zero, carry, busy);
    end
    repeat (2) @(posedge clk);
    #1; rst = 1'b0; #1;
    total++;
    if (in_ready !== 1'b1) begin bad++; $display("FAIL post_reset_ready got %b want 1", in_ready); end
  endtask

  task automatic test_addu_carry();
    run_op(6'h09, 32'hFFFFFFFF, 32'h1, 5'd0, "addu_wrap");
    total++;
    if ({result, carry, zero} !== {32'h0, 1'b1, 1'b1}) begin
      bad++; $display("FAIL addu_wrap_const got %h c=%b z=%b want 0 c=1 z=1", result, carry, zero);
    end
  endtask

  task automatic test_sub_shift();
    run_op(6'h0A, 32'd3, 32'd5, 5'd0, "subu_borrow");
    total++;
    if ({result, carry} !== {32'hFFFFFFFE, 1'b1}) begin
      bad++; $display("FAIL subu_const got %h c=%b want fffffffe c=1", result, carry);
    end
    run_op(6'h21, 32'h80000001, 32'h0, 5'd1, "sll_carry");
    total++;
    if ({result, carry} !== {32'h2, 1'b1}) begin
      bad++; $display("FAIL sll_const got %h c=%b want 00000002 c=1", result, carry);
    end
    run_op(6'h22, 32'h3, 32'h0, 5'd1, "srl_carry");
    total++;
    if ({result, carry} !== {32'h1, 1'b1}) begin
      bad++; $display("FAIL srl_const got %h c=%b want 00000001 c=1", result, carry);
    end
  endtask

  task automatic test_multu_max();
    run_op(6'h19, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd0, "multu_max");
    total++;
    if ({result, result_hi, carry, zero} !== {32'h1, 32'hFFFFFFFE, 1'b1, 1'b0}) begin
      bad++;
      $display("FAIL multu_max_const got lo=%h hi=%h c=%b z=%b want 00000001 fffffffe 1 0",
               result, result_hi, carry, zero);
    end
  endtask

  task automatic test_back_to_back();
    drain();
    out_ready = 1'b0;
    funct = 6'h12; src1 = 32'hF0F0F0F0; src2 = 32'h0F0F0F0F; shamt = '0; in_valid = 1'b1;
    @(posedge clk); #1;
    funct = 6'h09; src1 = 32'd1; src2 = 32'd1;
    for (int i = 0; i < 5; i++) begin
      total++;
      if ({out_valid, result, in_ready} !== {1'b1, 32'hFFFFFFFF, 1'b0}) begin
        bad++;
        $display("FAIL hold_%0d got v=%b lo=%h rdy=%b want v=1 lo=ffffffff rdy=0",
                 i, out_valid, result, in_ready);
      end
      @(posedge clk); #1;
    end
    out_ready = 1'b1; #1;
    total++;
    if (in_ready !== 1'b1) begin bad++; $display("FAIL consume_ready got %b want 1", in_ready); end
    @(posedge clk); #1;
    in_valid = 1'b0;
    total++;
    if ({out_valid, result, carry} !== {1'b1, 32'd2, 1'b0}) begin
      bad++; $display("FAIL same_edge_accept got v=%b lo=%h c=%b want v=1 lo=2 c=0", out_valid, result, carry);
    end
    @(posedge clk); #1;
    total++;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL consumed_clear got %b want 0", out_valid); end
  endtask

  task automatic test_reset_mid_mul();
    int seen;
    drain();
    funct = 6'h19; src1 = 32'd7; src2 = 32'd6; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (9) begin @(posedge clk); #1; end
    total++;
    if (busy !== 1'b1) begin bad++; $display("FAIL mid_mul_busy got %b want 1", busy); end
    rst = 1'b1; #1;
    total++;
    if ({in_ready, out_valid, result, result_hi, zero, carry, busy} !== '0) begin
      bad++;
      $display("FAIL abort_outputs got rdy=%b v=%b lo=%h hi=%h z=%b c=%b busy=%b want all 0",
               in_ready, out_valid, result, result_hi, zero, carry, busy);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (out_valid === 1'b1) seen++;
      @(posedge clk); #1;
    end
    total++;
    if (seen !== 0) begin bad++; $display("FAIL abort_no_result got %0d valid cycles want 0", seen); end
    run_op(6'h19, 32'd7, 32'd6, 5'd0, "multu_after_abort");
    total++;
    if ({result, result_hi} !== {32'd42, 32'd0}) begin
      bad++; $display("FAIL multu_42 got lo=%0d hi=%0d want 42 0", result, result_hi);
    end
  endtask

  task automatic test_illegal();
    run_op(6'h3F, 32'd5, 32'd9, 5'd3, "illegal");
    total++;
    if ({result, zero, carry} !== {32'd0, 1'b1, 1'b0}) begin
      bad++; $display("FAIL illegal_const got lo=%h z=%b c=%b want 0 z=1 c=0", result, zero, carry);
    end
  endtask

  task automatic test_random();
    logic [5:0] fl [8];
    logic [W-1:0] a, b;
    fl = '{6'h09, 6'h0A, 6'h11, 6'h12, 6'h21, 6'h22, 6'h19, 6'h2C};
    for (int i = 0; i < 40; i++) begin
      a = $urandom;
      b = $urandom;
      if (i % 5 == 0) b = b >> $urandom_range(0, 31);
      run_op(fl[$urandom_range(0, 7)], a, b, SW'($urandom), "random");
    end
  endtask

  initial begin
    test_reset();
    test_addu_carry();
    test_sub_shift();
    test_multu_max();
    test_back_to_back();
    test_reset_mid_mul();
    test_illegal();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
